// File: rtl/instr_mem_responder.sv
// ----------------------------------------------------------------------------
// instr_mem_responder
//
// Instruction-memory responder for the program counter's fetch interface.
// A fetch request (byte address) is accepted in IDLE. The addressed 32-bit
// word is returned WAIT_STATES cycles later on a valid/ready response
// channel. Misaligned or out-of-range addresses produce an error response
// that carries RESET_INSTR (a NOP). The word store is filled through an
// independent loader port, which is active in every state, including reset.
//
// Ports:
//   clk        in   1      clock; all state updates on posedge
//   rst        in   1      synchronous reset, active-high
//   req_valid  in   1      fetch request present
//   req_ready  out  1      responder can accept a request (IDLE only)
//   req_addr   in   32     byte address from the program counter
//   rsp_valid  out  1      response present (RESP only)
//   rsp_ready  in   1      consumer accepts the response
//   rsp_instr  out  32     fetched instruction word
//   rsp_addr   out  32     byte address of the request behind this response
//   rsp_err    out  1      misaligned or out-of-range fetch
//   load_en    in   1      loader write strobe
//   load_idx   in   IDX_W  loader word index
//   load_data  in   32     loader write data
// ----------------------------------------------------------------------------
module instr_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] RESET_INSTR = 32'h00000013,
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_instr,
    output logic [31:0]      rsp_addr,
    output logic             rsp_err,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [31:0]      load_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

    // The range check uses the full word address so high addresses never
    // alias onto the store.
    function automatic logic addr_is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       rsp_addr_q, rsp_addr_d;
    logic              perr_q, perr_d;      // error flag of the pending fetch
    logic [31:0]       rsp_instr_q;
    logic              rsp_err_q;
    logic              do_read;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_err;

    // Loader port: no reset, so preloading works while rst is held.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_idx] <= load_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_addr_d = rsp_addr_q;
        perr_d     = perr_q;
        do_read    = 1'b0;
        rd_idx     = rsp_addr_q[IDX_W+1:2];
        rd_err     = perr_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rsp_addr_d = req_addr;
                    perr_d     = addr_is_bad(req_addr);
                    if (WAIT_STATES == 0) begin
                        // Zero wait states: read straight off the request.
                        state_d = S_RESP;
                        do_read = 1'b1;
                        rd_idx  = req_addr[IDX_W+1:2];
                        rd_err  = addr_is_bad(req_addr);
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    do_read = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            rsp_addr_q  <= 32'd0;
            perr_q      <= 1'b0;
            rsp_instr_q <= RESET_INSTR;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_addr_q <= rsp_addr_d;
            perr_q     <= perr_d;
            // Non-blocking read of mem_q gives old data on a same-edge load.
            if (do_read) begin
                rsp_err_q   <= rd_err;
                rsp_instr_q <= rd_err ? RESET_INSTR : mem_q[rd_idx];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_instr = rsp_instr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_responder
//
// Directed bench for instr_mem_responder (DEPTH_WORDS=1024, WAIT_STATES=2).
// Stimulus pushes the expected response into a queue when a fetch is issued;
// a monitor pops and compares on every completed response handshake.
// Cycle-level properties (req_ready/rsp_valid timing, hold under
// backpressure, dropped fetch on reset) are checked inline.
// ----------------------------------------------------------------------------
module tb_instr_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        load_en;
    logic [9:0]  load_idx;
    logic [31:0] load_data;

    instr_mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS),
        .RESET_INSTR(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_addr (rsp_addr),
        .rsp_err  (rsp_err),
        .load_en  (load_en),
        .load_idx (load_idx),
        .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] addr, input logic err);
        exp_t e;
        e.instr = instr;
        e.addr  = addr;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        load_en   = 1'b1;
        load_idx  = idx;
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    // Bounded wait for a response, then let it complete with rsp_ready=1.
    task automatic wait_rsp(input string name);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        if (!rsp_valid) chk({name, "_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] instr, input logic err,
                         input string name);
        int n = 0;
        rsp_ready = 1'b1;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) chk({name, "_ready_timeout"}, 32'd0, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        push_exp(instr, addr, err);
        tick();
        req_valid = 1'b0;
        wait_rsp(name);
    endtask

    // Monitor: compare each completed response against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_instr", rsp_instr, e.instr);
                    chk("rsp_addr", rsp_addr, e.addr);
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        load_idx  = 10'd0;
        load_data = 32'd0;

        // Preload while reset is held (the loader works during reset).
        load(10'd3, 32'hDEADBEEF);
        load(10'd4, 32'h44444444);
        load(10'd5, 32'h22222222);
        load(10'd1023, 32'hCAFEF00D);
        rst = 1'b0;
        #1;

        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_instr", rsp_instr, NOP);
        chk("reset_rsp_addr", rsp_addr, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);

        // Basic fetch: accept in cycle c, response in c+3, ready again in c+4.
        req_valid = 1'b1;
        req_addr  = 32'h0000000C;
        chk("basic_ready_c", 32'(req_ready), 32'd1);
        push_exp(32'hDEADBEEF, 32'h0000000C, 1'b0);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            chk($sformatf("basic_ready_c%0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("basic_valid_c%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        chk("basic_valid_c3", 32'(rsp_valid), 32'd1);
        chk("basic_ready_c3", 32'(req_ready), 32'd0);
        tick();
        chk("basic_valid_c4", 32'(rsp_valid), 32'd0);
        chk("basic_ready_c4", 32'(req_ready), 32'd1);

        // Backpressure: response held while a second request waits.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0000000C;
        push_exp(32'hDEADBEEF, 32'h0000000C, 1'b0);
        tick();
        req_addr = 32'h00000010;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp_instr_%0d", i), rsp_instr, 32'hDEADBEEF);
            chk($sformatf("bp_addr_%0d", i), rsp_addr, 32'h0000000C);
            chk($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
        push_exp(32'h44444444, 32'h00000010, 1'b0);
        tick();
        req_valid = 1'b0;
        chk("bp_second_accepted", 32'(req_ready), 32'd0);
        wait_rsp("bp_second");

        // Error cases and the last legal word.
        fetch(32'h00000006, NOP, 1'b1, "err_misaligned");
        fetch(32'h00001000, NOP, 1'b1, "err_range");
        fetch(32'h8000000C, NOP, 1'b1, "err_high_alias");
        fetch(32'h00000FFC, 32'hCAFEF00D, 1'b0, "last_word");

        // Collision: load on the read edge returns the old word.
        req_valid = 1'b1;
        req_addr  = 32'h00000014;
        push_exp(32'h22222222, 32'h00000014, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        load(10'd5, 32'h11111111);
        wait_rsp("collision_old");
        fetch(32'h00000014, 32'h11111111, 1'b0, "collision_new");

        // Reset in the first WAIT cycle drops the fetch.
        req_valid = 1'b1;
        req_addr  = 32'h0000000C;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_instr", rsp_instr, NOP);
        chk("midrst_addr", rsp_addr, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("midrst_valid_%0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        fetch(32'h0000000C, 32'hDEADBEEF, 1'b0, "after_rst");

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder at the far end of the program counter's fetch-address interface.
- Accepts a fetch request carrying the PC value and returns the addressed 32-bit instruction after a configurable number of wait states.
- Uses a valid/ready handshake on both the request and response sides.
- Holds a word-addressed instruction store, written through a separate loader port (boot loader / testbench preload), and flags misaligned or out-of-range fetches.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit instruction words; power of two; IDX_W = log2(DEPTH_WORDS).
- WAIT_STATES, 2: extra cycles between request accept and response; legal range 0..15.
- RESET_INSTR, 32'h00000013: value driven on rsp_instr at reset and on error responses (RV32I NOP, addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address from the program counter.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  32  fetched instruction word.
- rsp_addr  out  32  byte address of the request that produced this response.
- rsp_err  out  1  set when req_addr[1:0]!=0 or req_addr[31:2] >= DEPTH_WORDS.
- load_en  in  1  loader write strobe.
- load_idx  in  IDX_W  loader word index.
- load_data  in  32  loader write data.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. Reset is sampled only at posedge clk.
- Reset values: state=IDLE, rsp_valid=0, rsp_instr=RESET_INSTR, rsp_addr=0, rsp_err=0, wait counter=0. Memory contents are not cleared.
- States: IDLE, WAIT, RESP.
  - req_ready is 1 only in IDLE, purely decoded from state.
  - rsp_valid is 1 only in RESP.
- IDLE:
  - Accept occurs on the edge where req_valid&&req_ready.
  - At accept, latch req_addr into rsp_addr and compute the error flag.
  - If WAIT_STATES==0, go directly to RESP and perform the read on that edge.
  - Otherwise load counter=WAIT_STATES and go to WAIT.
  - req_addr is sampled only at accept; req_valid dropping before accept has no effect.
- WAIT:
  - Counter decrements each edge.
  - On the edge where counter==1, go to RESP and perform the read.
  - Request inputs are ignored.
- Read:
  - If error: rsp_instr=RESET_INSTR, rsp_err=1, and memory is not accessed.
  - Otherwise: rsp_instr=mem[rsp_addr[IDX_W+1:2]], rsp_err=0.
- Latency: an accept in cycle c gives rsp_valid=1 first in cycle c+1+WAIT_STATES.
- RESP:
  - rsp_instr, rsp_addr and rsp_err are held stable while rsp_ready=0.
  - On the edge with rsp_ready=1, go to IDLE and clear rsp_valid.
  - req_ready stays 0 throughout RESP.
  - Peak throughput is one fetch per WAIT_STATES+2 cycles.
- rsp_ready is ignored outside RESP.
- Loader:
  - When load_en=1, mem[load_idx] <= load_data on the edge, in any state, including during reset.
  - A load in the same edge as a read of the same index returns the OLD data (read-before-write).
- Reset mid-operation: an in-flight request in WAIT or RESP is dropped with no response. The cycle after reset deassertion, req_ready=1.
- Address arithmetic: the index uses bits [IDX_W+1:2]. The range check uses the full req_addr[31:2] compared against DEPTH_WORDS, so there is no aliasing of high addresses.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release -> rsp_valid=0, req_ready=1, rsp_instr=0x00000013, rsp_addr=0, rsp_err=0.
- Basic fetch (WAIT_STATES=2): load idx 3=0xDEADBEEF; request 0x0000000C in cycle c with rsp_ready=1 -> req_ready=0 in c+1..c+3; rsp_valid=1 only in c+3 with rsp_instr=0xDEADBEEF, rsp_addr=0x0C, rsp_err=0; req_ready=1 in c+4.
- Backpressure: fetch idx 3, then hold rsp_ready=0 for 5 cycles while driving req_valid=1 with addr 0x10 -> outputs stay 0xDEADBEEF/0x0C, req_ready=0, second request not accepted; raise rsp_ready -> IDLE next cycle, then 0x10 is accepted.
- Errors: request 0x00000006 -> rsp_err=1, rsp_instr=0x00000013; request 0x00001000 (DEPTH_WORDS=1024) -> rsp_err=1; request 0x00000FFC -> rsp_err=0.
- Collision: mem[5]=0x22222222; load idx 5=0x11111111 on the read edge of a fetch to 0x14 -> response 0x22222222; the next fetch of 0x14 -> 0x11111111.
- Reset mid-WAIT: accept 0x0C, assert rst in the first WAIT cycle -> rsp_valid never rises for that request; req_ready=1 the cycle after rst drops; a new fetch completes normally.
